// File: rtl/mult_pkg.sv
// Shared constants and FSM state type for the round-robin multiplier scheduler.
package mult_pkg;
  localparam int MULT_W = 4;
  localparam int PROD_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } mult_sched_state_t;
endpackage

// File: rtl/bit_4_multiplier.sv
// Unsigned 4x4 combinational multiplier producing a full 8-bit product.
module bit_4_multiplier (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] out
);
  assign out = {4'b0000, a} * {4'b0000, b};
endmodule

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one 4x4 multiplier among NREQ requesters,
// one operation in flight, result returned over a valid/ready channel.
module mult_rr_scheduler
  import mult_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [MULT_W*NREQ-1:0]   req_a,
  input  logic [MULT_W*NREQ-1:0]   req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [PROD_W-1:0]        rsp_out,
  output logic [IDW-1:0]           rsp_id
);

  mult_sched_state_t state_q, state_d;
  logic [IDW-1:0]    last_q, last_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [MULT_W-1:0] op_a_q, op_a_d;
  logic [MULT_W-1:0] op_b_q, op_b_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic [PROD_W-1:0] mult_out;

  logic [IDW-1:0]    start_idx;
  logic [NREQ-1:0]   rot_valid;
  logic [IDW-1:0]    pick_off;
  logic [IDW-1:0]    grant_idx;
  logic              grant_en;
  logic [MULT_W-1:0] sel_a;
  logic [MULT_W-1:0] sel_b;

  // Index arithmetic modulo NREQ (NREQ need not be a power of two).
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Rotate so the slot after the last winner is bit 0, take the lowest set
  // bit, then rotate the offset back into a requester index.
  always_comb begin
    start_idx = wrap_add(last_q, 1);
    rot_valid = '0;
    for (int k = 0; k < NREQ; k++) begin
      rot_valid[k] = req_valid[wrap_add(start_idx, k)];
    end
    pick_off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) pick_off = IDW'(k);
    end
    grant_idx = wrap_add(start_idx, int'(pick_off));
    grant_en  = (state_q == IDLE) && (|req_valid);
    sel_a     = req_a[grant_idx*MULT_W +: MULT_W];
    sel_b     = req_b[grant_idx*MULT_W +: MULT_W];
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign req_ready[gi] = grant_en && (grant_idx == IDW'(gi));
  end

  bit_4_multiplier u_mult (
    .a   (op_a_q),
    .b   (op_b_q),
    .out (mult_out)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (grant_en) begin
          op_a_d  = sel_a;
          op_b_d  = sel_b;
          id_d    = grant_idx;
          last_d  = grant_idx;
          state_d = CALC;
        end
      end
      CALC: begin
        prod_d  = mult_out;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IDW'(NREQ - 1);
      id_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      prod_q  <= prod_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_out   = prod_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed self-checking bench for mult_rr_scheduler with NREQ = 4.
module tb_mult_rr_scheduler;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [15:0]     req_a;
  logic [15:0]     req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [7:0]      rsp_out;
  logic [IDW-1:0]  rsp_id;

  int tests  = 0;
  int errors = 0;

  mult_rr_scheduler #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_a = '0; req_b = '0;
    do_reset();
    #1;
    tests++;
    if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || rsp_out !== 8'd0 || rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b out=%0d id=%0d required 0000/0/0/0",
               req_ready, rsp_valid, rsp_out, rsp_id);
    end
    $display("[TB] reset: ready=%b valid=%b out=%0d id=%0d", req_ready, rsp_valid, rsp_out, rsp_id);
  endtask

  task automatic test_single();
    req_valid = 4'b0001; req_a = 16'h0009; req_b = 16'h0006; rsp_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL single_ready: got %b required 0001", req_ready);
    end
    cyc(); req_valid = '0; #1;
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL single_calc: valid=%b ready=%b required 0/0000", rsp_valid, req_ready);
    end
    cyc(); #1;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_out !== 8'd54 || rsp_id !== 2'd0) begin
      errors++; $display("FAIL single_rsp: valid=%b out=%0d id=%0d required 1/54/0", rsp_valid, rsp_out, rsp_id);
    end
    $display("[TB] single: out=%0d id=%0d", rsp_out, rsp_id);
    cyc(); #1;
    tests++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL single_done: valid=%b required 0", rsp_valid);
    end
  endtask

  task automatic test_all_rotate();
    int acc_cyc[5];
    int rid[5];
    int rout[5];
    int exp_id[5]  = '{0, 1, 2, 3, 0};
    int exp_out[5] = '{36, 90, 54, 225, 36};
    int n_acc = 0;
    int n_rsp = 0;
    do_reset();
    req_a = {4'd15, 4'd6, 4'd9, 4'd6};
    req_b = {4'd15, 4'd9, 4'd10, 4'd6};
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int c = 0; c < 40 && n_rsp < 5; c++) begin
      #1;
      if (req_ready != 4'b0000 && n_acc < 5) begin
        acc_cyc[n_acc] = c; n_acc++;
      end
      if (rsp_valid) begin
        rid[n_rsp] = int'(rsp_id); rout[n_rsp] = int'(rsp_out); n_rsp++;
      end
      cyc();
    end
    req_valid = '0;
    tests++;
    if (n_rsp != 5) begin
      errors++; $display("FAIL rotate_timeout: got %0d responses required 5", n_rsp);
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests++;
        if (rid[i] != exp_id[i] || rout[i] != exp_out[i]) begin
          errors++;
          $display("FAIL rotate_rsp%0d: id=%0d out=%0d required id=%0d out=%0d",
                   i, rid[i], rout[i], exp_id[i], exp_out[i]);
        end
        $display("[TB] rotate rsp%0d: id=%0d out=%0d", i, rid[i], rout[i]);
        if (i > 0) begin
          tests++;
          if (acc_cyc[i] - acc_cyc[i-1] != 3) begin
            errors++;
            $display("FAIL rotate_spacing%0d: got %0d cycles required 3", i, acc_cyc[i] - acc_cyc[i-1]);
          end
        end
      end
    end
    // Drain to IDLE (last response handshaked in the loop).
    cyc();
  endtask

  task automatic test_pair();
    int rid[2];
    int rout[2];
    int n_rsp = 0;
    bit bad_grant = 0;
    do_reset();
    req_a = {4'd7, 4'd0, 4'd2, 4'd0};
    req_b = {4'd5, 4'd0, 4'd3, 4'd0};
    req_valid = 4'b0010; rsp_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL pair_prime: got %b required 0010", req_ready);
    end
    cyc(); req_valid = '0; cyc(); cyc();
    req_valid = 4'b1010;
    for (int c = 0; c < 30 && n_rsp < 2; c++) begin
      #1;
      if ((req_ready & 4'b0101) != 4'b0000) bad_grant = 1;
      if (rsp_valid) begin
        rid[n_rsp] = int'(rsp_id); rout[n_rsp] = int'(rsp_out); n_rsp++;
      end
      cyc();
    end
    req_valid = '0;
    tests++;
    if (n_rsp != 2) begin
      errors++; $display("FAIL pair_timeout: got %0d responses required 2", n_rsp);
    end else begin
      tests++;
      if (rid[0] != 3 || rout[0] != 35 || rid[1] != 1 || rout[1] != 6) begin
        errors++;
        $display("FAIL pair_order: got id=%0d/%0d out=%0d/%0d required 3/1 35/6",
                 rid[0], rid[1], rout[0], rout[1]);
      end
      $display("[TB] pair: ids %0d,%0d outs %0d,%0d", rid[0], rid[1], rout[0], rout[1]);
    end
    tests++;
    if (bad_grant) begin
      errors++; $display("FAIL pair_idle_grant: req0/req2 granted, required never");
    end
    cyc(); cyc(); cyc();
  endtask

  task automatic test_backpressure();
    req_a = 16'h0009; req_b = 16'h000A;
    req_valid = 4'b0001; rsp_ready = 1'b0;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL bp_accept: got %b required 0001", req_ready);
    end
    cyc(); cyc();
    for (int s = 0; s < 5; s++) begin
      #1;
      tests++;
      if (rsp_valid !== 1'b1 || rsp_out !== 8'd90 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_stall%0d: valid=%b out=%0d id=%0d ready=%b required 1/90/0/0000",
                 s, rsp_valid, rsp_out, rsp_id, req_ready);
      end
      cyc();
    end
    rsp_ready = 1'b1; #1;
    tests++;
    if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL bp_handshake: valid=%b ready=%b required 1/0000", rsp_valid, req_ready);
    end
    $display("[TB] backpressure: out=%0d id=%0d", rsp_out, rsp_id);
    cyc(); #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL bp_next_accept: got %b required 0001", req_ready);
    end
    cyc(); req_valid = '0; cyc(); cyc();
  endtask

  task automatic test_reset_midflight();
    bit stale;
    // Reset while in CALC.
    req_a = 16'h0009; req_b = 16'h000A; req_valid = 4'b0001; rsp_ready = 1'b1;
    cyc(); req_valid = '0; rst = 1'b1; cyc(); rst = 1'b0; #1;
    tests++;
    if (rsp_valid !== 1'b0 || rsp_out !== 8'd0 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rst_calc: valid=%b out=%0d id=%0d ready=%b required 0/0/0/0000",
               rsp_valid, rsp_out, rsp_id, req_ready);
    end
    stale = 0;
    for (int c = 0; c < 3; c++) begin cyc(); if (rsp_valid) stale = 1; end
    tests++;
    if (stale) begin errors++; $display("FAIL rst_calc_stale: rsp_valid seen, required none"); end
    // Reset while stalled in RESP.
    req_a = 16'h0090; req_b = 16'h00A0; req_valid = 4'b0010; rsp_ready = 1'b0;
    cyc(); req_valid = '0; cyc(); #1;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_out !== 8'd90) begin
      errors++; $display("FAIL rst_resp_pre: valid=%b out=%0d required 1/90", rsp_valid, rsp_out);
    end
    cyc(); rst = 1'b1; cyc(); rst = 1'b0; #1;
    tests++;
    if (rsp_valid !== 1'b0 || rsp_out !== 8'd0 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rst_resp: valid=%b out=%0d id=%0d ready=%b required 0/0/0/0000",
               rsp_valid, rsp_out, rsp_id, req_ready);
    end
    stale = 0;
    for (int c = 0; c < 3; c++) begin cyc(); if (rsp_valid) stale = 1; end
    tests++;
    if (stale) begin errors++; $display("FAIL rst_resp_stale: rsp_valid seen, required none"); end
    // Re-issue from req2.
    req_a = 16'h0600; req_b = 16'h0600; req_valid = 4'b0100; rsp_ready = 1'b1; #1;
    tests++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL rst_reissue_ready: got %b required 0100", req_ready);
    end
    cyc(); req_valid = '0; cyc(); #1;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_out !== 8'd36 || rsp_id !== 2'd2) begin
      errors++; $display("FAIL rst_reissue_rsp: valid=%b out=%0d id=%0d required 1/36/2", rsp_valid, rsp_out, rsp_id);
    end
    $display("[TB] reset midflight reissue: out=%0d id=%0d", rsp_out, rsp_id);
    cyc();
  endtask

  task automatic test_boundary();
    logic [3:0] ta[2] = '{4'd0, 4'd15};
    int         exp_p[2] = '{0, 225};
    for (int i = 0; i < 2; i++) begin
      req_a = {12'h000, ta[i]}; req_b = 16'h000F; req_valid = 4'b0001; rsp_ready = 1'b1;
      cyc(); req_valid = '0; cyc(); #1;
      tests++;
      if (rsp_valid !== 1'b1 || int'(rsp_out) != exp_p[i] || rsp_id !== 2'd0) begin
        errors++;
        $display("FAIL boundary%0d: valid=%b out=%0d id=%0d required 1/%0d/0",
                 i, rsp_valid, rsp_out, rsp_id, exp_p[i]);
      end
      $display("[TB] boundary %0d*15: out=%0d", ta[i], rsp_out);
      cyc();
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    test_reset();
    test_single();
    test_all_rotate();
    test_pair();
    test_backpressure();
    test_reset_midflight();
    test_boundary();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/mult_rr_scheduler.md
# mult_rr_scheduler

Round-robin scheduler sharing one 4x4 combinational multiplier (`bit_4_multiplier`) among `NREQ` requesters. Each requester offers an operand pair over a valid/ready handshake. The scheduler grants one requester at a time, registers the operands into the shared multiplier and registers the 8-bit product. It returns the product with the winning requester's ID over a valid/ready response channel. It sits between the per-lane arithmetic clients and the multiplier datapath.

## Interface
- `NREQ`, default 4: number of requesters, valid range 2..8.
- `IDW`, default `$clog2(NREQ)`: width of the response ID. Derived; not overridden.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  NREQ  bit i set: requester i presents operands.
- `req_ready`  out  NREQ  bit i set: requester i's operands are accepted this cycle.
- `req_a`  in  4*NREQ  operand A; requester i on bits [4i+3:4i].
- `req_b`  in  4*NREQ  operand B; same packing as `req_a`.
- `rsp_valid`  out  1  product and ID are valid.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_out`  out  8  unsigned product a*b.
- `rsp_id`  out  IDW  index of the requester that issued the operation.

## Operation
- FSM states: IDLE, CALC, RESP. Reset state is IDLE.
- IDLE
  - If any `req_valid` bit is set, pick a winner g by round-robin.
  - Search starts at `last+1` and wraps modulo NREQ.
  - Assert `req_ready[g]` only, combinationally, in the same cycle.
  - Latch `req_a[g]`, `req_b[g]` into operand registers `op_a`, `op_b` and g into `id_q`.
  - Set `last <= g` and go to CALC.
  - If no `req_valid` bit is set, stay in IDLE and drive `req_ready` = 0.
- CALC
  - `op_a`/`op_b` drive the multiplier.
  - Register its 8-bit output into `prod_q`.
  - Go to RESP.
- RESP
  - `rsp_valid` = 1; `rsp_out` = `prod_q`; `rsp_id` = `id_q`.
  - Hold all three stable until `rsp_ready` = 1.
  - On `rsp_valid && rsp_ready`, go to IDLE.
  - Arbitration for the next request happens in the following cycle.
- Only one operation is in flight; `req_ready` is 0 in every state except IDLE.
- A requester that is not granted keeps `req_valid` asserted. The scheduler places no obligation on requesters to drop `req_valid`.
- Round-robin rule: the requester granted last has the lowest priority on the next grant. With all requesters valid, grants rotate 0,1,...,NREQ-1,0.
- Arithmetic: unsigned 4x4 to 8 bits. Maximum 15*15 = 225, so no overflow and no truncation.
- Reset values
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_out` = 0, `rsp_id` = 0.
  - `op_a` = 0, `op_b` = 0, `prod_q` = 0.
  - `last` = NREQ-1, so requester 0 wins first after reset.

## Timing
- Accept at cycle T (`req_valid[g] && req_ready[g]`):
  - CALC at T+1.
  - `rsp_valid` = 1 from T+2.
- Minimum spacing between accepts is 3 cycles (with `rsp_ready` held high).
- Back-pressure adds one cycle per cycle that `rsp_ready` is low in RESP.
- `req_ready` depends combinationally on `req_valid` and the state. No other output is combinational from inputs.
- `rsp_ready` asserted outside RESP is ignored.
- A requester dropping `req_valid` in the cycle it would have been granted simply loses arbitration. Grant is evaluated on the current `req_valid` only.
- `rst` asserted in any state, including mid-CALC or a stalled RESP:
  - Next edge returns to IDLE with the reset values above.
  - The in-flight result is discarded and never presented.

## Structure
- Shared package `mult_pkg`:
  - `MULT_W` = 4 and `PROD_W` = 8.
  - FSM state enum `mult_sched_state_t` {IDLE, CALC, RESP}.
- One sub-module: the existing `bit_4_multiplier` (ports `a`, `b`, `out`), instantiated once and driven from `op_a`/`op_b`.
- Round-robin winner selection stays in this module. It is a rotate, priority-encode, unrotate function of `req_valid` and `last`.

## Test plan
- After reset, only req0 valid with a=9, b=6 and `rsp_ready` = 1 -> `req_ready` = 0001 in the first IDLE cycle. Two cycles later `rsp_valid` = 1, `rsp_out` = 54, `rsp_id` = 0.
- All four requesters valid, operand pairs (6,6), (9,10), (6,9), (15,15), held continuously -> responses in ID order 0,1,2,3,0 with products 36, 90, 54, 225, 36. Each accept is exactly 3 cycles apart.
- req1 and req3 valid, last grant = 1 -> req3 granted next, then req1. req0 and req2 are never granted.
- `rsp_ready` low for 5 cycles in RESP with a=9, b=10 -> `rsp_valid`, `rsp_out` = 90 and `rsp_id` stable throughout. `req_ready` = 0 throughout. The next accept occurs in the cycle after the handshake.
- `rst` pulsed in CALC, and separately in a stalled RESP -> next cycle `rsp_valid` = 0, all outputs 0, and no stale response. Re-issue a=6, b=6 from req2 -> `rsp_out` = 36, `rsp_id` = 2.
- Boundary operands 0*15 and 15*15 -> `rsp_out` = 0 and 225 respectively.
